// File: rtl/fb_pkg.sv
// Shared constants, state type and helpers for the ping-pong picture frame buffer.
// Optional feature macro used by the top: FB_DROP_CNT_EN (dropped-write counter).
package fb_pkg;

    localparam int FB_DATA_W   = 8;
    localparam int FB_ADDR_W   = 10;
    localparam int FB_DEPTH    = 784;
    localparam int FB_NUM_RD   = 2;
    localparam int FRAME_CNT_W = 8;
    localparam int DROP_CNT_W  = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } fb_state_t;

    function automatic logic addr_in_range(input int unsigned addr, input int unsigned depth);
        return addr < depth;
    endfunction

endpackage

// File: rtl/fb_bank.sv
// One DEPTH x DATA_W picture bank: 1 write port, NUM_RD registered read ports.
// Latency: read data 1 cycle after address; out-of-range addresses read as 0.
// Backpressure: none, the bank accepts one write and NUM_RD reads every cycle.
module fb_bank
    import fb_pkg::*;
#(
    parameter int DATA_W = FB_DATA_W,
    parameter int ADDR_W = FB_ADDR_W,
    parameter int DEPTH  = FB_DEPTH,
    parameter int NUM_RD = FB_NUM_RD
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [NUM_RD*ADDR_W-1:0] raddr,
    output logic [NUM_RD*DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // The caller guarantees waddr < DEPTH whenever we is set.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data_q;

        assign addr = raddr[i*ADDR_W +: ADDR_W];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                data_q <= '0;
            end else if (addr_in_range(32'(addr), DEPTH)) begin
                data_q <= mem[addr];
            end else begin
                data_q <= '0;
            end
        end

        assign rdata[i*DATA_W +: DATA_W] = data_q;
    end

endmodule

// File: rtl/pic_frame_buffer.sv
// Ping-pong frame buffer: receiver fills the write bank, NUM_RD readers scan the published bank.
// Latency: read data 1 cycle after address; swap visible 1 cycle after frame done / last release.
// Backpressure: wr_ready drops while a finished frame waits for readers to release (FB_DROP_CNT_EN adds drop_cnt).
module pic_frame_buffer
    import fb_pkg::*;
#(
    parameter int DATA_W = FB_DATA_W,
    parameter int ADDR_W = FB_ADDR_W,
    parameter int DEPTH  = FB_DEPTH,
    parameter int NUM_RD = FB_NUM_RD
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     wr_frame_done,
    output logic                     wr_ready,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    input  logic [NUM_RD-1:0]        rd_release,
    output logic [NUM_RD-1:0]        rd_valid,
`ifdef FB_DROP_CNT_EN
    output logic [FRAME_CNT_W-1:0]   frame_cnt,
    output logic [DROP_CNT_W-1:0]    drop_cnt
`else
    output logic [FRAME_CNT_W-1:0]   frame_cnt
`endif
);

    fb_state_t state, state_nxt;
    logic      wb;
    logic      rb_q;
    logic      do_swap;
    logic      swap_ok;
    logic      wr_in_range;
    logic      wr_accept;

    logic [NUM_RD*DATA_W-1:0] bank0_rdata;
    logic [NUM_RD*DATA_W-1:0] bank1_rdata;

    assign wr_ready    = (state == ST_IDLE);
    assign wr_in_range = addr_in_range(32'(wr_addr), DEPTH);
    assign wr_accept   = wr_en & wr_ready & wr_in_range;

    // A reader releasing in this very cycle no longer holds the frame.
    assign swap_ok = ~|(rd_valid & ~rd_release);

    always_comb begin
        state_nxt = state;
        do_swap   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (wr_frame_done) begin
                    if (swap_ok) begin
                        do_swap = 1'b1;
                    end else begin
                        state_nxt = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (swap_ok) begin
                    do_swap   = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            wb        <= 1'b0;
            rb_q      <= 1'b1;
            rd_valid  <= '0;
            frame_cnt <= '0;
        end else begin
            state <= state_nxt;
            // Tracks which bank the read registers sampled this cycle.
            rb_q  <= ~wb;
            if (do_swap) begin
                wb        <= ~wb;
                rd_valid  <= '1;
                frame_cnt <= frame_cnt + 1'b1;
            end else begin
                rd_valid  <= rd_valid & ~rd_release;
            end
        end
    end

    fb_bank #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .NUM_RD (NUM_RD)
    ) u_bank0 (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (wr_accept & ~wb),
        .waddr (wr_addr),
        .wdata (wr_data),
        .raddr (rd_addr),
        .rdata (bank0_rdata)
    );

    fb_bank #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .NUM_RD (NUM_RD)
    ) u_bank1 (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (wr_accept & wb),
        .waddr (wr_addr),
        .wdata (wr_data),
        .raddr (rd_addr),
        .rdata (bank1_rdata)
    );

    assign rd_data = rb_q ? bank1_rdata : bank0_rdata;

`ifdef FB_DROP_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= '0;
        end else if (wr_en && !(wr_ready && wr_in_range) && (drop_cnt != '1)) begin
            drop_cnt <= drop_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: doc/pic_frame_buffer.md
# pic_frame_buffer

Parametrised ping-pong image frame buffer that replaces the single-bank 1-write/2-read picture RAM between the Bluetooth picture receiver and the image consumers (VGA display, CNN, future readers). Two banks alternate roles: the receiver fills the write bank while NUM_RD independent readers scan the published read bank. A completed frame is published by a bank swap, which waits until every reader has released the previous frame. This gives readers a stable image and lets the receiver start the next one immediately.

## Interface
- DATA_W, 8: pixel width.
- ADDR_W, 10: address width.
- DEPTH, 784: pixels per frame (28x28); must satisfy DEPTH <= 2**ADDR_W.
- NUM_RD, 2: number of read ports.

- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- wr_en  in  1  write strobe; accepted only when wr_ready=1.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write pixel.
- wr_frame_done  in  1  single-cycle pulse: current write bank holds a complete frame.
- wr_ready  out  1  write bank accepts writes.
- rd_addr  in  NUM_RD*ADDR_W  packed read addresses; port i uses bits [i*ADDR_W +: ADDR_W].
- rd_data  out  NUM_RD*DATA_W  packed registered read data.
- rd_release  in  NUM_RD  per-reader pulse: finished with the current frame.
- rd_valid  out  NUM_RD  per-reader level: a published frame is pending for that reader.
- frame_cnt  out  8  count of published frames; wraps 255->0.

## Operation
- State: wb (write bank index), rb = ~wb, pending flag, rd_valid vector.
- Reset values: wb=0, pending=0, wr_ready=1, rd_valid=0, rd_data=0, frame_cnt=0. Memory contents are not cleared.
- Write: when wr_en=1, wr_ready=1 and wr_addr<DEPTH, write wr_data into bank wb. Writes with wr_addr>=DEPTH are dropped silently.
- Read: each port reads bank rb. rd_data is 0 when rd_addr>=DEPTH. Reads do not depend on rd_valid.
- Release: rd_release[i] clears rd_valid[i]. A release when rd_valid[i]=0 is ignored.
- Swap condition: no reader still holds the frame, i.e. (rd_valid & ~rd_release)==0, evaluated in the same cycle.
- States:
  - IDLE (pending=0). On wr_frame_done:
    - If the swap condition holds, swap: wb<=~wb, rd_valid<=all ones, frame_cnt+1. Stay in IDLE.
    - Otherwise go to HOLD: pending=1, wr_ready=0.
  - HOLD (pending=1): all writes are dropped and further wr_frame_done pulses are ignored. When the swap condition holds, swap as above, clear pending, set wr_ready=1, and return to IDLE.
- Simultaneous events:
  - A write in the same cycle as wr_frame_done lands in the old write bank before the swap.
  - A release in the same cycle as a swap is consumed by the old frame; rd_valid for the new frame is still all ones.
- Reset mid-frame: returns to the reset state immediately; any partially written or published frame is abandoned.

## Timing
- rd_data is valid 1 cycle after rd_addr. It reflects the bank that was rb in the address cycle.
- After a swap in cycle t: rd_valid=all ones, the new rb and the updated frame_cnt are all visible at t+1. The first read of the new frame is issued at t+1 and returns data at t+2.
- wr_ready falls the cycle after wr_frame_done when the swap is blocked. It rises the cycle after the last blocking release.
- Throughput: 1 write and NUM_RD reads per cycle.

## Configuration
- FB_DROP_CNT_EN defined:
  - Adds output drop_cnt [15:0], reset to 0.
  - Increments, saturating at 16'hFFFF, on every wr_en=1 that is dropped: either wr_ready=0 or wr_addr>=DEPTH.
- FB_DROP_CNT_EN undefined: the port and the counter are absent; there is no other behavioural change.

## Structure
- Package fb_pkg: default DATA_W/ADDR_W/DEPTH/NUM_RD constants and the FRAME_CNT_W=8 constant.
- Sub-module fb_bank: one DEPTH x DATA_W bank with 1 write port and NUM_RD registered read ports; instanced twice.
- The top level holds the swap control, the rd_valid vector and the read-data mux selected by the registered rb.

## Test plan
- Reset, write pixels 0..783 with value addr[7:0], pulse wr_frame_done -> rd_valid=2'b11, frame_cnt=1; reading addr 5 on port 1 returns 8'h05 one cycle later.
- Frame 1 published and unreleased, write frame 2 (value 8'hAA) and pulse done -> wr_ready=0. Release port 0 -> still 0. Release port 1 -> wr_ready=1 next cycle; reads return 8'hAA and frame_cnt=2.
- While wr_ready=0, write 8'h55 to addr 0 -> dropped; after the swap, addr 0 still reads 8'hAA. With FB_DROP_CNT_EN, drop_cnt=1.
- Read addr 800 on both ports -> rd_data=0. Write to addr 800 -> ignored; with FB_DROP_CNT_EN, drop_cnt increments.
- Last release arrives in the same cycle as wr_frame_done -> immediate swap, no HOLD; rd_valid=2'b11 the next cycle.
- Assert rst_n low while in HOLD -> wr_ready=1, rd_valid=0, frame_cnt=0 immediately, without waiting for a clock edge.
